// File: rtl/ctc_pkg.sv
// ----------------------------------------------------------------------------
// Package: ctc_pkg
// Constants and types shared by the serial-instruction-bus blocks. It holds
// the word-time states of the instruction capture window, the instruction
// type codes, the whole-word opcodes that the address sequencer decodes, the
// layout of a captured instruction word, and the next-address select codes.
// ----------------------------------------------------------------------------
package ctc_pkg;

    // Word-time states on sys_cnt
    localparam logic [5:0] T_FIRST     = 6'd0;   // first state of a word time
    localparam logic [5:0] T_ITYPE0    = 6'd45;  // itype[0] is on IS here
    localparam logic [5:0] T_BODY0     = 6'd47;  // body[0] is on IS here
    localparam logic [5:0] T_BODY_LAST = 6'd54;  // body[7] is on IS here; word complete
    localparam logic [5:0] T_LAST      = 6'd55;  // decode state

    // Instruction type field (word[1:0])
    localparam logic [1:0] ITYPE_JSB = 2'b01;
    localparam logic [1:0] ITYPE_BRN = 2'b11;

    // Whole-word opcodes
    localparam logic [9:0] OP_RTN    = 10'b00_0011_0000;
    localparam logic [9:0] OP_KEYJMP = 10'b00_1101_0000;

    // Captured instruction word; IS delivers it LSB first
    typedef struct packed {
        logic [7:0] body;
        logic [1:0] itype;
    } is_word_t;

    // Source of the next ROM address
    typedef enum logic [2:0] {
        NXT_INC,   // adr + 1
        NXT_ZERO,  // power-on
        NXT_JUMP,  // body of JSB / taken branch
        NXT_POP,   // return address
        NXT_KEY    // key code
    } nxt_sel_e;

endpackage

// File: rtl/is_deser.sv
// ----------------------------------------------------------------------------
// Module: is_deser
// Gated 10-bit serial-to-parallel shifter for the instruction bus. IS is
// shifted in LSB first during T45..T54; the assembled word is stable from
// T55 until the next T45. After reset the shifter stays idle until it sees
// a T45, so a word cut short by reset never produces a partial capture.
// Ports:
//   i_clk      in   system clock
//   i_rst_n    in   asynchronous active-low reset
//   i_sys_cnt  in   word-time state
//   i_is       in   serial instruction bus
//   o_word     out  captured instruction word {body, itype}
// ----------------------------------------------------------------------------
module is_deser
    import ctc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_sys_cnt,
    input  logic       i_is,
    output is_word_t   o_word
);

    logic       r_armed;
    logic [9:0] r_sr;
    logic       w_in_win;
    logic       w_shift;

    assign w_in_win = (i_sys_cnt >= T_ITYPE0) && (i_sys_cnt <= T_BODY_LAST);
    // A capture may only begin at the first bit of a word.
    assign w_shift  = w_in_win && (r_armed || (i_sys_cnt == T_ITYPE0));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed <= 1'b0;
            r_sr    <= '0;
        end else begin
            if (i_sys_cnt == T_ITYPE0)
                r_armed <= 1'b1;
            if (w_shift)
                r_sr <= {i_is, r_sr[9:1]};
        end
    end

    assign o_word = is_word_t'(r_sr);

endmodule

// File: rtl/rom_adr_seq.sv
// ----------------------------------------------------------------------------
// Module: rom_adr_seq
// ROM address sequencer for the serial instruction bus. Captures each
// instruction word from IS, decides the next ROM address at the last state
// of the word time and serializes the current address on IA, LSB first.
// Handles increment, branch on no carry, JSB/RTN and the key-code jump.
// Ports:
//   cph2     in   system clock (posedge)
//   nrst     in   asynchronous active-low reset
//   sys_cnt  in   word-time state 0..WORD_LEN-1; larger values are idle
//   pon      in   power-on; forces the address to 0 and silences IA
//   is       in   serial instruction bus
//   carry    in   datapath carry
//   kcode    in   latched key code
//   ia       out  serial ROM address
//   adr      out  current ROM address
//   rtn_adr  out  top-of-stack return address
//   rtn_adr2 out  second stack level (only with ROM_ADR_SEQ_STACK2_EN)
// Configuration macro: ROM_ADR_SEQ_STACK2_EN selects a two-level return stack.
// ----------------------------------------------------------------------------
module rom_adr_seq
    import ctc_pkg::*;
#(
    parameter int ADR_W      = 8,
    parameter int T_IA_START = 4,
    parameter int WORD_LEN   = 56
) (
    input  logic             cph2,
    input  logic             nrst,
    input  logic [5:0]       sys_cnt,
    input  logic             pon,
    input  logic             is,
    input  logic             carry,
    input  logic [5:0]       kcode,
    output logic             ia,
    output logic [ADR_W-1:0] adr,
    output logic [ADR_W-1:0] rtn_adr
`ifdef ROM_ADR_SEQ_STACK2_EN
    ,
    output logic [ADR_W-1:0] rtn_adr2
`endif
);

    localparam logic [5:0] T_DECODE = 6'(WORD_LEN - 1);
    localparam logic [5:0] IA_FIRST = 6'(T_IA_START);

    is_word_t         w_word;
    nxt_sel_e         w_sel;
    logic             w_push;
    logic [ADR_W-1:0] w_adr_inc;
    logic [ADR_W-1:0] w_adr_nxt;
    logic             w_ia_bit;

    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_rtn_adr;
    logic             r_carry_f;
    logic             r_carry_acc;
`ifdef ROM_ADR_SEQ_STACK2_EN
    logic [ADR_W-1:0] r_rtn_adr2;
`endif

    is_deser u_is_deser (
        .i_clk     (cph2),
        .i_rst_n   (nrst),
        .i_sys_cnt (sys_cnt),
        .i_is      (is),
        .o_word    (w_word)
    );

    // Wraps modulo 2^ADR_W with no flag.
    assign w_adr_inc = r_adr + ADR_W'(1);

    // Next-address priority. r_carry_f still holds the previous word's carry
    // here, which is what the branch must test.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel  = NXT_INC;
        w_push = 1'b0;
        if (pon) begin
            w_sel = NXT_ZERO;
        end else if (w_word.itype == ITYPE_JSB) begin
            w_sel  = NXT_JUMP;
            w_push = 1'b1;
        end else if (w_word.itype == ITYPE_BRN) begin
            w_sel = r_carry_f ? NXT_INC : NXT_JUMP;
        end else if (w_word == OP_RTN) begin
            w_sel = NXT_POP;
        end else if (w_word == OP_KEYJMP) begin
            w_sel = NXT_KEY;
        end
    end

    always_comb begin
        w_adr_nxt = w_adr_inc;
        case (w_sel)
            NXT_ZERO: w_adr_nxt = '0;
            NXT_JUMP: w_adr_nxt = ADR_W'(w_word.body);
            NXT_POP:  w_adr_nxt = r_rtn_adr;
            NXT_KEY:  w_adr_nxt = ADR_W'(kcode);
            default:  w_adr_nxt = w_adr_inc;
        endcase
    end

    // IA serializer: bit i of adr goes out in state IA_FIRST+i; out-of-window
    // and idle states leave the default of 0.
    always_comb begin
        w_ia_bit = 1'b0;
        for (int i = 0; i < ADR_W; i++) begin
            if (sys_cnt == IA_FIRST + 6'(i))
                w_ia_bit = r_adr[i];
        end
    end

    assign ia = w_ia_bit & ~pon;

    always_ff @(posedge cph2 or negedge nrst) begin
        if (!nrst) begin
            r_adr       <= '0;
            r_rtn_adr   <= '0;
            r_carry_f   <= 1'b0;
            r_carry_acc <= 1'b0;
`ifdef ROM_ADR_SEQ_STACK2_EN
            r_rtn_adr2  <= '0;
`endif
        end else begin
            // Carry seen anywhere in the word, restarted at T0.
            if (sys_cnt == T_FIRST)
                r_carry_acc <= carry;
            else if (sys_cnt < T_DECODE)
                r_carry_acc <= r_carry_acc | carry;

            if (sys_cnt == T_DECODE) begin
                r_carry_f <= r_carry_acc | carry;
                r_adr     <= w_adr_nxt;
`ifdef ROM_ADR_SEQ_STACK2_EN
                if (w_push) begin
                    r_rtn_adr2 <= r_rtn_adr;
                    r_rtn_adr  <= w_adr_inc;
                end else if (w_sel == NXT_POP) begin
                    // Bottom entry is kept, so it duplicates after a pop.
                    r_rtn_adr  <= r_rtn_adr2;
                end
`else
                if (w_push)
                    r_rtn_adr <= w_adr_inc;
`endif
            end
        end
    end

    assign adr     = r_adr;
    assign rtn_adr = r_rtn_adr;
`ifdef ROM_ADR_SEQ_STACK2_EN
    assign rtn_adr2 = r_rtn_adr2;
`endif

endmodule

// File: tb/tb_rom_adr_seq.sv
// ----------------------------------------------------------------------------
// Testbench: tb_rom_adr_seq
// Plays the timing block (sys_cnt) and instruction ROM (IS) for rom_adr_seq.
// A reference model predicts the address decided at each T55; the expected
// adr/rtn_adr and the expected IA byte for the following word are queued
// when a word is driven and popped when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_rom_adr_seq;

    localparam logic [9:0] W_NOP = 10'h000;
    localparam logic [9:0] W_RTN = 10'b00_0011_0000;
    localparam logic [9:0] W_KEY = 10'b00_1101_0000;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] rtn;
        logic [7:0] rtn2;
    } exp_t;

    logic       cph2 = 1'b0;
    logic       nrst;
    logic [5:0] sys_cnt;
    logic       pon;
    logic       is;
    logic       carry;
    logic [5:0] kcode;
    logic       ia;
    logic [7:0] adr;
    logic [7:0] rtn_adr;
`ifdef ROM_ADR_SEQ_STACK2_EN
    logic [7:0] rtn_adr2;
`endif

    int n_total = 0;
    int n_bad   = 0;

    exp_t       exp_q[$];
    logic [7:0] ia_q[$];

    // Reference model state
    logic [7:0] m_adr;
    logic [7:0] m_rtn;
    logic [7:0] m_rtn2;
    logic       m_cf;

    always #5 cph2 = ~cph2;

    rom_adr_seq dut (
        .cph2    (cph2),
        .nrst    (nrst),
        .sys_cnt (sys_cnt),
        .pon     (pon),
        .is      (is),
        .carry   (carry),
        .kcode   (kcode),
        .ia      (ia),
        .adr     (adr),
        .rtn_adr (rtn_adr)
`ifdef ROM_ADR_SEQ_STACK2_EN
        ,
        .rtn_adr2 (rtn_adr2)
`endif
    );

    // Model of the T55 decision; updates model state and queues expectations.
    task automatic model_decode(input logic [9:0] w, input logic carry_seen,
                                input logic pon_v, input logic [5:0] kc);
        logic [7:0] body;
        logic [7:0] nadr;
        exp_t       e;
        body = w[9:2];
        nadr = m_adr + 8'd1;
        if (pon_v) begin
            nadr = 8'h00;
        end else if (w[1:0] == 2'b01) begin
            m_rtn2 = m_rtn;
            m_rtn  = m_adr + 8'd1;
            nadr   = body;
        end else if (w[1:0] == 2'b11) begin
            nadr = m_cf ? m_adr + 8'd1 : body;
        end else if (w == W_RTN) begin
            nadr = m_rtn;
`ifdef ROM_ADR_SEQ_STACK2_EN
            m_rtn = m_rtn2;
`endif
        end else if (w == W_KEY) begin
            nadr = {2'b00, kc};
        end
        m_adr  = nadr;
        m_cf   = carry_seen;
        e.adr  = m_adr;
        e.rtn  = m_rtn;
        e.rtn2 = m_rtn2;
        exp_q.push_back(e);
        ia_q.push_back(m_adr);
    endtask

    // Drives one full word time, checks IA against the scoreboard, then checks
    // the address decided at T55.
    task automatic run_word(input logic [9:0] w, input int carry_at,
                            input logic pon_v, input logic [5:0] kc);
        logic [7:0] ia_byte;
        logic [7:0] ia_exp;
        exp_t       e;
        ia_byte = '0;
        for (int s = 0; s < 56; s++) begin
            @(negedge cph2);
            sys_cnt = 6'(s);
            is      = (s >= 45 && s <= 54) ? w[s-45] : 1'b0;
            carry   = (s == carry_at);
            pon     = pon_v;
            kcode   = kc;
            #1;
            if (s >= 4 && s <= 11)
                ia_byte[s-4] = ia;
            if (s == 3 || s == 12) begin
                n_total++;
                if (ia !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ia_outside_window s=%0d: got %b want 0", s, ia);
                end
            end
            if (s == 11) begin
                n_total++;
                if (ia_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ia_queue: empty, got %h", ia_byte);
                end else begin
                    ia_exp = ia_q.pop_front();
                    if (pon_v) ia_exp = 8'h00;
                    if (ia_byte !== ia_exp) begin
                        n_bad++;
                        $display("FAIL ia_byte: got %h want %h", ia_byte, ia_exp);
                    end
                end
            end
        end
        model_decode(w, (carry_at >= 0 && carry_at <= 55), pon_v, kc);
        @(posedge cph2);
        #1;
        e = exp_q.pop_front();
        n_total++;
        if (adr !== e.adr) begin
            n_bad++;
            $display("FAIL adr word=%h: got %h want %h", w, adr, e.adr);
        end
        n_total++;
        if (rtn_adr !== e.rtn) begin
            n_bad++;
            $display("FAIL rtn_adr word=%h: got %h want %h", w, rtn_adr, e.rtn);
        end
`ifdef ROM_ADR_SEQ_STACK2_EN
        n_total++;
        if (rtn_adr2 !== e.rtn2) begin
            n_bad++;
            $display("FAIL rtn_adr2 word=%h: got %h want %h", w, rtn_adr2, e.rtn2);
        end
`endif
    endtask

    task automatic test_reset;
        nrst = 1'b0; sys_cnt = 6'd4; pon = 1'b0; is = 1'b0; carry = 1'b0; kcode = '0;
        repeat (3) @(negedge cph2);
        #1;
        n_total++;
        if (adr !== 8'h00) begin n_bad++; $display("FAIL reset_adr: got %h want 00", adr); end
        n_total++;
        if (rtn_adr !== 8'h00) begin n_bad++; $display("FAIL reset_rtn: got %h want 00", rtn_adr); end
        n_total++;
        if (ia !== 1'b0) begin n_bad++; $display("FAIL reset_ia: got %b want 0", ia); end
        @(negedge cph2);
        sys_cnt = 6'd63;
        nrst    = 1'b1;
        m_adr = 8'h00; m_rtn = 8'h00; m_rtn2 = 8'h00; m_cf = 1'b0;
        ia_q.push_back(8'h00);
    endtask

    task automatic test_increment;
        for (int n = 0; n < 4; n++)
            run_word(W_NOP, -1, 1'b0, 6'h00);
        n_total++;
        if (adr !== 8'h04) begin n_bad++; $display("FAIL increment: got %h want 04", adr); end
    endtask

    task automatic test_jsb_rtn;
        run_word({8'h10, 2'b11}, -1, 1'b0, 6'h00);  // branch to 0x10, no prior carry
        run_word({8'h5A, 2'b01}, -1, 1'b0, 6'h00);  // JSB 0x5A
        n_total++;
        if (adr !== 8'h5A || rtn_adr !== 8'h11) begin
            n_bad++;
            $display("FAIL jsb: got adr=%h rtn=%h want adr=5a rtn=11", adr, rtn_adr);
        end
        run_word(W_RTN, -1, 1'b0, 6'h00);
        n_total++;
        if (adr !== 8'h11) begin n_bad++; $display("FAIL rtn: got %h want 11", adr); end
    endtask

    task automatic test_branch;
        run_word(W_NOP, 20, 1'b0, 6'h00);           // carry pulsed at T20
        run_word({8'h40, 2'b11}, -1, 1'b0, 6'h00);  // branch not taken
        n_total++;
        if (adr !== 8'h13) begin n_bad++; $display("FAIL branch_carry: got %h want 13", adr); end
        run_word({8'h40, 2'b11}, -1, 1'b0, 6'h00);  // branch taken
        n_total++;
        if (adr !== 8'h40) begin n_bad++; $display("FAIL branch_nocarry: got %h want 40", adr); end
    endtask

    task automatic test_wrap;
        run_word({8'hFF, 2'b11}, -1, 1'b0, 6'h00);
        run_word(W_NOP, -1, 1'b0, 6'h00);
        n_total++;
        if (adr !== 8'h00) begin n_bad++; $display("FAIL wrap: got %h want 00", adr); end
        run_word(W_NOP, -1, 1'b0, 6'h00);           // IA of 0x00 checked here
    endtask

    task automatic test_keyjmp;
        run_word(W_KEY, -1, 1'b0, 6'h2B);
        n_total++;
        if (adr !== 8'h2B) begin n_bad++; $display("FAIL keyjmp: got %h want 2b", adr); end
    endtask

    task automatic test_pon_jsb;
        logic [7:0] rtn_before;
        rtn_before = rtn_adr;
        run_word({8'h77, 2'b01}, -1, 1'b1, 6'h00);
        n_total++;
        if (adr !== 8'h00 || rtn_adr !== m_rtn) begin
            n_bad++;
            $display("FAIL pon_jsb: got adr=%h rtn=%h want adr=00 rtn=%h (before %h)",
                     adr, rtn_adr, m_rtn, rtn_before);
        end
        run_word(W_NOP, -1, 1'b0, 6'h00);
    endtask

    task automatic test_idle;
        for (int s = 56; s < 64; s++) begin
            @(negedge cph2);
            sys_cnt = 6'(s); is = 1'b1; carry = 1'b0; pon = 1'b0;
            #1;
            n_total++;
            if (ia !== 1'b0) begin n_bad++; $display("FAIL idle_ia s=%0d: got %b want 0", s, ia); end
        end
        @(posedge cph2);
        #1;
        n_total++;
        if (adr !== m_adr) begin n_bad++; $display("FAIL idle_adr: got %h want %h", adr, m_adr); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] w;
        logic [7:0] ia_byte;
        logic [7:0] ia_exp;
        w = {8'h5A, 2'b01};
        ia_byte = '0;
        for (int s = 0; s < 56; s++) begin
            @(negedge cph2);
            sys_cnt = 6'(s);
            is      = (s >= 45) ? ((s <= 54) ? w[s-45] : 1'b0) : 1'b0;
            if (s >= 52) is = 1'b1;
            carry   = 1'b0;
            pon     = 1'b0;
            if (s == 50) nrst = 1'b0;
            if (s == 52) nrst = 1'b1;
            #1;
            if (s >= 4 && s <= 11) ia_byte[s-4] = ia;
            if (s == 11) begin
                ia_exp = ia_q.pop_front();
                n_total++;
                if (ia_byte !== ia_exp) begin
                    n_bad++;
                    $display("FAIL reset_mid_ia: got %h want %h", ia_byte, ia_exp);
                end
            end
            if (s == 50) begin
                n_total++;
                if (adr !== 8'h00 || rtn_adr !== 8'h00 || ia !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_mid_zero: got adr=%h rtn=%h ia=%b want 00 00 0",
                             adr, rtn_adr, ia);
                end
            end
        end
        m_adr = 8'h00; m_rtn = 8'h00; m_rtn2 = 8'h00; m_cf = 1'b0;
        exp_q.delete();
        ia_q.delete();
        model_decode(W_NOP, 1'b0, 1'b0, 6'h00);
        @(posedge cph2);
        #1;
        void'(exp_q.pop_front());
        n_total++;
        if (adr !== 8'h01 || rtn_adr !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_decode: got adr=%h rtn=%h want 01 00", adr, rtn_adr);
        end
        run_word(W_NOP, -1, 1'b0, 6'h00);
    endtask

`ifdef ROM_ADR_SEQ_STACK2_EN
    task automatic test_stack2;
        logic [7:0] first_ret;
        first_ret = m_adr + 8'd1;
        run_word({8'h30, 2'b01}, -1, 1'b0, 6'h00);
        run_word({8'h50, 2'b01}, -1, 1'b0, 6'h00);
        run_word(W_RTN, -1, 1'b0, 6'h00);
        n_total++;
        if (adr !== 8'h31) begin n_bad++; $display("FAIL stack2_pop1: got %h want 31", adr); end
        run_word(W_RTN, -1, 1'b0, 6'h00);
        n_total++;
        if (adr !== first_ret) begin
            n_bad++;
            $display("FAIL stack2_pop2: got %h want %h", adr, first_ret);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_increment();
        test_jsb_rtn();
        test_branch();
        test_wrap();
        test_keyjmp();
        test_pon_jsb();
        test_idle();
        test_reset_mid();
`ifdef ROM_ADR_SEQ_STACK2_EN
        test_stack2();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
